pc_fetch_unit: RTL

- Parametrised program-counter and instruction-fetch sequencer for the MIPS32 core (NucleoTop family).
- Replaces the bare pc_in/reset_pc PC register with:
  - configurable width, reset vector and increment;
  - prioritised redirects (load, jump, branch);
  - a req/ack fetch handshake tolerating variable memory latency;
  - stall support.
- Sits between the control/branch logic and the instruction memory; feeds the decode stage.

---
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-fetch bus between pc_fetch_unit (master) and instruction memory (slave).
// fetch_req/fetch_addr stay asserted and stable until the memory returns fetch_ack.
interface pc_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ack;
    logic [DATA_WIDTH-1:0] fetch_data;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer with prioritised redirects and req/ack fetch.
// Optional macro PC_MISALIGN_CHECK_EN: misaligned redirect targets trap to EXC_VECTOR.
//
// state  | meaning
// IDLE   | no request outstanding; waits for stall to drop
// REQ    | first cycle of a fetch request (zero-wait ack completes here)
// WAIT   | request held with stable address until fetch_ack
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned           PC_INC       = 4,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(32'h0000_0180)
) (
    input  logic                  clk,
    input  logic                  reset_pc,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  pc_load,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  stall,
    pc_fetch_unit_if.master       fetch,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  misaligned
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

    logic [1:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc_r, pc_nxt;
    logic [ADDR_WIDTH-1:0] pend_target, pend_target_nxt;
    logic                  pend_valid, pend_valid_nxt;
    logic                  redir;
    logic [ADDR_WIDTH-1:0] redir_target;
    logic                  take;
    logic [ADDR_WIDTH-1:0] take_target;
    logic                  deliver;
    logic                  mis_set;

    always_comb begin
        redir        = pc_load | jump | branch_taken;
        redir_target = branch_target;
        if (pc_load) begin
            redir_target = pc_in;
        end else if (jump) begin
            redir_target = jump_target;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc_r;
        pend_target_nxt = pend_target;
        pend_valid_nxt  = pend_valid;
        take            = 1'b0;
        take_target     = redir_target;
        deliver         = 1'b0;
        mis_set         = 1'b0;

        case (state)
            S_IDLE: begin
                if (redir) begin
                    take = 1'b1;
                end
                if (!stall) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                if (fetch.fetch_ack) begin
                    // A redirect seen now or earlier in this request squashes the returned word
                    if (redir) begin
                        take           = 1'b1;
                        pend_valid_nxt = 1'b0;
                    end else if (pend_valid) begin
                        take           = 1'b1;
                        take_target    = pend_target;
                        pend_valid_nxt = 1'b0;
                    end else begin
                        deliver = 1'b1;
                        pc_nxt  = pc_r + INC;
                    end
                    state_nxt = stall ? S_IDLE : S_REQ;
                end else begin
                    if (redir) begin
                        pend_target_nxt = redir_target;
                        pend_valid_nxt  = 1'b1;
                    end
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (take) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (take_target[1:0] != 2'b00) begin
                pc_nxt  = EXC_VECTOR;
                mis_set = 1'b1;
            end else begin
                pc_nxt = take_target;
            end
`else
            pc_nxt = take_target;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset_pc) begin
        if (reset_pc) begin
            state       <= S_IDLE;
            pc_r        <= RESET_VECTOR;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc_r        <= pc_nxt;
            pend_target <= pend_target_nxt;
            pend_valid  <= pend_valid_nxt;
            instr_valid <= deliver;
            if (deliver) begin
                instr    <= fetch.fetch_data;
                instr_pc <= pc_r;
            end
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic misaligned_r;

    always_ff @(posedge clk or posedge reset_pc) begin
        if (reset_pc) begin
            misaligned_r <= 1'b0;
        end else if (mis_set) begin
            misaligned_r <= 1'b1;
        end
    end

    assign misaligned = misaligned_r;
`else
    // Targets are used verbatim; the trap path and its flag do not exist in this build
    logic unused_mis;
    assign unused_mis = mis_set ^ (|EXC_VECTOR);
    assign misaligned = 1'b0;
`endif

    assign fetch.fetch_req  = (state == S_REQ) || (state == S_WAIT);
    assign fetch.fetch_addr = pc_r;
    assign pc               = pc_r;

endmodule
